trace_sequencer: RTL and testbench

//  Synthesizable front end for the cache simulator. Walks a trace ROM of word

---
 rtl/trace_sequencer.sv | 98 +++++++++
 tb/tb_trace_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_sequencer.sv
// Trace-driven front end for the cache simulator: walks a trace ROM and feeds each address to the cache.
// Optional SEQ_STALL_EN adds a cache_ready input so a multi-cycle cache can hold the search phase.
module trace_sequencer #(
    parameter int TRACE_SIZE = 57962,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  rom_idx,
    input  logic [ADDR_W-1:0] rom_data,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_state,
    input  logic              cache_hit,
`ifdef SEQ_STALL_EN
    input  logic              cache_ready,
`endif
    output logic [CNT_W-1:0]  ref_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, SEARCH, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACE_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state;
    logic   advance;

`ifdef SEQ_STALL_EN
    assign advance = cache_ready;
`else
    assign advance = 1'b1;
`endif

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rom_idx     <= '0;
            cache_addr  <= '0;
            cache_state <= 1'b0;
            ref_count   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= ISSUE;
                        rom_idx     <= '0;
                        ref_count   <= '0;
                        hit_count   <= '0;
                        miss_count  <= '0;
                        cache_state <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ISSUE: begin
                    cache_addr  <= rom_data;
                    cache_state <= 1'b1;
                    state       <= SEARCH;
                end
                SEARCH: begin
                    if (advance) begin
                        ref_count <= sat_inc(ref_count);
                        if (cache_hit) hit_count  <= sat_inc(hit_count);
                        else           miss_count <= sat_inc(miss_count);
                        cache_state <= 1'b0;
                        // Index holds on the last entry so the ROM is never read out of range.
                        if (rom_idx == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rom_idx <= rom_idx + IDX_W'(1);
                            state   <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_sequencer.sv
// Randomized scoreboard bench for trace_sequencer: a trace/cache model predicts each reference
// and the run totals; a negedge monitor compares whenever the DUT presents a search or finishes.
module tb_trace_sequencer;

    localparam int TS   = 8;
    localparam int AW   = 16;
    localparam int IW   = 3;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] rom_idx;
    logic [AW-1:0] rom_data;
    logic [AW-1:0] cache_addr;
    logic          cache_state;
    logic          cache_hit;
    logic [CW-1:0] ref_count, hit_count, miss_count;
    logic          busy, done;

    logic [AW-1:0] rom [TS];
    logic          hit_vec [TS];
    int            stall_len [TS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_idx];
    assign cache_hit = cache_state & hit_vec[rom_idx];

`ifdef SEQ_STALL_EN
    logic cache_ready;
    int   search_cyc = 0;
    always @(negedge clk) search_cyc <= cache_state ? search_cyc + 1 : 0;
    assign cache_ready = !cache_state || (search_cyc > stall_len[rom_idx]);
`endif

    trace_sequencer #(.TRACE_SIZE(TS), .ADDR_W(AW), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_idx(rom_idx), .rom_data(rom_data),
        .cache_addr(cache_addr), .cache_state(cache_state), .cache_hit(cache_hit),
`ifdef SEQ_STALL_EN
        .cache_ready(cache_ready),
`endif
        .ref_count(ref_count), .hit_count(hit_count), .miss_count(miss_count),
        .busy(busy), .done(done)
    );

    typedef struct { logic [AW-1:0] addr; int r; int h; int m; } exp_t;
    typedef struct { int r; int h; int m; } fin_t;
    exp_t exp_q[$];
    fin_t fin_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Predict a run from the trace contents: mode 0 all miss, 1 all hit,
    // 2 hit when the address already appeared earlier in the trace, 3 random hits.
    task automatic plan(input int mode, output int cycles);
        int h;
        logic seen;
        h = 0;
        cycles = 0;
        for (int i = 0; i < TS; i++) begin
            seen = 1'b0;
            for (int j = 0; j < i; j++) if (rom[j] == rom[i]) seen = 1'b1;
            case (mode)
                0:       hit_vec[i] = 1'b0;
                1:       hit_vec[i] = 1'b1;
                2:       hit_vec[i] = seen;
                default: hit_vec[i] = 1'($urandom_range(0, 1));
            endcase
`ifdef SEQ_STALL_EN
            stall_len[i] = int'($urandom_range(0, 3));
`else
            stall_len[i] = 0;
`endif
            exp_q.push_back('{rom[i], sat(i), sat(h), sat(i - h)});
            if (hit_vec[i]) h++;
            cycles += 2 + stall_len[i];
        end
        fin_q.push_back('{sat(TS), sat(h), sat(TS - h)});
    endtask

    // Done becomes visible right after edge number 2N (+stalls) past the start edge.
    task automatic run(input int mode, input bit busy_pulse);
        int exp_cyc, n;
        plan(mode, exp_cyc);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (done || n > 400) break;
            start = busy_pulse && (n == 5);
        end
        start = 1'b0;
        chk("latency", n, exp_cyc);
        chk("idx_hold", rom_idx, TS - 1);
        chk("busy_done", busy, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: a search-phase entry consumes one expected reference, a rising done one total.
    initial begin
        logic prev_cs, prev_done;
        exp_t cur;
        prev_cs = 1'b0;
        prev_done = 1'b0;
        cur = '{'0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cs = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (cache_state) begin
                    if (!prev_cs) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ref: got search at idx %0d expected none", rom_idx);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("busy_in_search", busy, 1);
                        end
                    end
                    chk("cache_addr", cache_addr, cur.addr);
                    chk("ref_before", ref_count, cur.r);
                    chk("hit_before", hit_count, cur.h);
                    chk("miss_before", miss_count, cur.m);
                end
                if (done && !prev_done) begin
                    if (fin_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        fin_t f;
                        f = fin_q.pop_front();
                        chk("final_ref", ref_count, f.r);
                        chk("final_hit", hit_count, f.h);
                        chk("final_miss", miss_count, f.m);
                    end
                end
                prev_cs = cache_state;
                prev_done = done;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < TS; i++) begin
            rom[i] = '0;
            hit_vec[i] = 1'b0;
            stall_len[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_idx", rom_idx, 0);
        chk("rst_addr", cache_addr, 0);
        chk("rst_cs", cache_state, 0);
        chk("rst_ref", ref_count, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Alternating pair pattern: every repeat is a hit.
        for (int i = 0; i < TS; i++) rom[i] = (i % 4 < 2) ? ((i % 2) ? 16'hBEEF : 16'h1234)
                                                       : ((i % 2) ? 16'h00C3 : 16'h5A5A);
        run(2, 1'b0);

        for (int i = 0; i < TS; i++) rom[i] = AW'($urandom);
        run(0, 1'b0);
        run(1, 1'b0);

        // Small alphabet for frequent repeats; start pulsed mid-run, then rerun from DONE.
        for (int i = 0; i < TS; i++) rom[i] = AW'($urandom_range(0, 3));
        run(2, 1'b1);
        run(2, 1'b0);

        // Abort during the search of the third reference.
        plan(2, n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if ((cache_state && rom_idx == 2) || n > 200) break;
        end
        chk("reached_ref3", n <= 200, 1);
        rst = 1'b1;
        exp_q.delete();
        fin_q.delete();
        #1;
        chk("abort_idx", rom_idx, 0);
        chk("abort_addr", cache_addr, 0);
        chk("abort_cs", cache_state, 0);
        chk("abort_ref", ref_count, 0);
        chk("abort_hit", hit_count, 0);
        chk("abort_miss", miss_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        run(2, 1'b0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < TS; i++) rom[i] = AW'($urandom_range(0, 5));
            run(3, k[0]);
        end

        chk("queues_drained", exp_q.size() + fin_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
